// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// uart_tx : UART transmitter, start + 8 data (LSB first) + optional parity + stop
// Rev 1.0 : initial release
// ============================================================================
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            prescale,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int          c_BIT_CNT_W = $clog2(DATA_WIDTH);
  localparam logic [c_BIT_CNT_W-1:0] c_LAST_BIT = c_BIT_CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                  r_state,     w_state_next;
  logic [5:0]              r_edge_cnt,  w_edge_next;
  logic [c_BIT_CNT_W-1:0]  r_bit_cnt,   w_bit_next;
  logic [DATA_WIDTH-1:0]   r_data,      w_data_next;
  logic                    r_par_en,    w_par_en_next;
  logic                    r_par_typ,   w_par_typ_next;
  logic [5:0]              r_prescale,  w_prescale_next;
  logic                    r_tx,        w_tx_next;
  logic                    r_busy,      w_busy_next;

  logic [5:0]              w_last_edge;
  logic                    w_bit_end;

  // Modulo-64 wrap makes prescale 0 behave as a 64-cycle bit.
  assign w_last_edge = r_prescale - 6'd1;
  assign w_bit_end   = (r_edge_cnt == w_last_edge);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_prescale <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_edge_cnt <= w_edge_next;
      r_bit_cnt  <= w_bit_next;
      r_data     <= w_data_next;
      r_par_en   <= w_par_en_next;
      r_par_typ  <= w_par_typ_next;
      r_prescale <= w_prescale_next;
      r_tx       <= w_tx_next;
      r_busy     <= w_busy_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_edge_next     = r_edge_cnt;
    w_bit_next      = r_bit_cnt;
    w_data_next     = r_data;
    w_par_en_next   = r_par_en;
    w_par_typ_next  = r_par_typ;
    w_prescale_next = r_prescale;
    w_tx_next       = 1'b1;
    w_busy_next     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_edge_next = '0;
        w_bit_next  = '0;
        if (DATA_VALID) begin
          w_data_next     = P_DATA;
          w_par_en_next   = PAR_EN;
          w_par_typ_next  = PAR_TYP;
          w_prescale_next = prescale;
          w_state_next    = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_edge_next  = '0;
          w_state_next = S_DATA;
        end else begin
          w_edge_next = r_edge_cnt + 6'd1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_edge_next = '0;
          if (r_bit_cnt == c_LAST_BIT) begin
            w_bit_next   = '0;
            w_state_next = r_par_en ? S_PARITY : S_STOP;
          end else begin
            w_bit_next = r_bit_cnt + 1'b1;
          end
        end else begin
          w_edge_next = r_edge_cnt + 6'd1;
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_edge_next  = '0;
          w_state_next = S_STOP;
        end else begin
          w_edge_next = r_edge_cnt + 6'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_edge_next  = '0;
          w_state_next = S_IDLE;
        end else begin
          w_edge_next = r_edge_cnt + 6'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_edge_next  = '0;
        w_bit_next   = '0;
      end
    endcase

    // Outputs are decoded from the upcoming state so the registers line up with it.
    unique case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_data_next[w_bit_next];
      S_PARITY: w_tx_next = (^w_data_next) ^ w_par_typ_next;
      default:  w_tx_next = 1'b1;
    endcase
    w_busy_next = (w_state_next != S_IDLE);
  end

  assign TX_OUT = r_tx;
  assign busy   = r_busy;

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serializes one byte per frame: start bit, 8 data bits LSB first, optional parity bit, and one stop bit. Each bit is held for `prescale` clock cycles, driven by an internal cycle counter. It is the transmit-side counterpart of the UART RX path and shares that path's `prescale` and parity configuration semantics. It accepts a byte via a valid/busy handshake and drives the serial line idle-high.

## Interface
- `DATA_WIDTH`, 8, payload bits per frame; fixed at 8 in this design.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-low reset, sampled on rising `clk`.
- `prescale`  in  6  clock cycles per bit; 1..63 legal, 0 means 64.
- `P_DATA`  in  8  byte to transmit; sampled only in the accept cycle.
- `DATA_VALID`  in  1  request to send `P_DATA`.
- `PAR_EN`  in  1  1 = insert parity bit after data.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity.
- `TX_OUT`  out  1  serial line, registered, idle high.
- `busy`  out  1  registered; high while a frame is in progress.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `TX_OUT`=1, `busy`=0.
  - If `DATA_VALID`=1, latch `P_DATA`, `PAR_EN`, `PAR_TYP` and `prescale`, then go to START.
- START: drive 0 for one bit period, then go to DATA.
- DATA:
  - Drive latched bit[`bit_cnt`], LSB first, with `bit_cnt` counting 0..7.
  - After bit 7 completes, go to PARITY if latched `PAR_EN`=1, otherwise go to STOP.
- PARITY: drive ^data for even parity, ~^data for odd parity, then go to STOP.
- STOP: drive 1 for one bit period, then go to IDLE.
- Bit period counter:
  - 6-bit `edge_cnt` counts 0..(prescale−1), computed modulo 64; the bit ends when `edge_cnt` equals that value.
  - `edge_cnt` clears to 0 at each bit end and in IDLE.
- Input handling while `busy`=1:
  - `DATA_VALID` is ignored; requests are not queued.
  - Changes to `P_DATA`, `PAR_EN`, `PAR_TYP` or `prescale` do not affect the current frame.
- Reset (`rst`=0 at a clock edge), including mid-frame:
  - Next state is IDLE.
  - `TX_OUT`=1, `busy`=0, `edge_cnt`=0, `bit_cnt`=0, data register=0.
  - A partial frame is abandoned with no stop-bit completion.

## Timing
- Accept cycle N is an IDLE cycle with `DATA_VALID`=1; `TX_OUT` is still 1 in this cycle.
- From cycle N+1:
  - `TX_OUT`=0 and `busy`=1.
  - Each bit occupies exactly P cycles, where P is the latched `prescale` (64 if 0).
- Frame length is (10 + PAR_EN)·P cycles, from N+1 through N+(10+PAR_EN)·P.
- `busy` stays high through the last stop-bit cycle and is 0 at cycle N+(10+PAR_EN)·P+1, which is an IDLE cycle.
- Back-to-back:
  - If `DATA_VALID` is high in that first IDLE cycle, the next start bit begins one cycle later.
  - The minimum inter-frame idle high is therefore 1 cycle beyond the stop bit.
- Outputs come directly from registers; there is no combinational path from any input to `TX_OUT` or `busy`.

## Test plan
- **Reset:**
  - Stimulus: hold `rst`=0 for 3 cycles with `DATA_VALID`=1.
  - Required: `TX_OUT`=1 and `busy`=0 throughout. After release, the first accept occurs on the first cycle with `rst`=1.
- **No parity, 0xA5:**
  - Stimulus: `prescale`=8, `PAR_EN`=0, `P_DATA`=0xA5.
  - Required: `TX_OUT` bits 0,1,0,1,0,0,1,0,1,1, each held 8 cycles. `busy` is high for 80 cycles.
- **Parity, 0xA5 (four ones):**
  - Stimulus: `PAR_EN`=1, `prescale`=16.
  - Required, `PAR_TYP`=0: parity bit 0. With `PAR_TYP`=1: parity bit 1.
  - Required for both: `busy` is high for 176 cycles.
- **Back-to-back frames:**
  - Stimulus: `prescale`=4, `DATA_VALID` held high continuously, 0x00 then 0xFF.
  - Required: second start bit begins exactly 1 cycle after the first frame's last stop cycle.
  - Required: mid-frame changes to `P_DATA`, `PAR_EN` and `prescale` have no effect on the frame in progress.
- **Abort and boundary prescale:**
  - Stimulus: assert `rst`=0 during data bit 3.
  - Required: `TX_OUT`=1 and `busy`=0 on the next cycle, and the next frame is normal.
  - Stimulus: `prescale`=0.
  - Required: 64 cycles per bit.
  - Stimulus: `prescale`=1.
  - Required: 1 cycle per bit, 10-cycle frame.
